// File: rtl/dconv_pkg.sv
// Shared definitions for the 3x3 convolution sequencer.
//   state_t     : sequencer FSM states
//   GAP_DEFAULT : default idle cycles between output rows
//   KRN_WORDS   : number of kernel words (one per kernel row) fetched per layer
package dconv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_STREAM,
    S_DRAIN,
    S_GAP,
    S_FIN
  } state_t;

  localparam int GAP_DEFAULT = 1;
  localparam int KRN_WORDS   = 3;

endpackage

// File: rtl/dconv_rd_delay.sv
// One-stage alignment of an SRAM read strobe with the SRAM's 1-cycle read
// latency, so the PE sees valid/last together with the returned data.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   rd_en       : read strobe issued to the SRAM
//   last        : marks the final read of a burst
//   valid       : rd_en delayed one cycle
//   input_last  : (rd_en & last) delayed one cycle
module dconv_rd_delay (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  input  logic last,
  output logic valid,
  output logic input_last
);

  // stage p0 -> p1: register strobe alongside the SRAM data return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      input_last <= 1'b0;
    end else begin
      valid      <= rd_en;
      input_last <= rd_en & last;
    end
  end

endmodule

// File: rtl/dconv_3x3_ctrl.sv
// Sequencer for one 3x3 convolution PE. On start it fetches the three kernel
// words, then streams the feature map one 3-pixel column per cycle, one output
// row at a time, waiting for each row's results to drain before the next.
// PE results are tagged with row/column indices for the writeback stage.
// Optional feature macro: DCONV_CTRL_PERF_EN adds perf_cycles (busy cycle
// count, cleared at start, saturating, held after done).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start, cfg_w, cfg_h        : layer start and geometry (latched at start)
//   krn_rd_en, krn_rd_addr     : kernel SRAM read
//   img_rd_en, img_rd_row/col  : line-buffer read (top row of window, column)
//   kernel_valid, image_valid  : to PE, aligned with SRAM read data
//   input_last                 : to PE, with the last image_valid of a row
//   pe_out_valid               : PE result strobe
//   res_valid, res_row, res_col: tagged result strobe for writeback
//   row_done, done             : 1-cycle pulses at row drain / layer end
//   busy                       : high whenever not idle
//   err                        : bad geometry (w<3 or h<3), held until next start
//   perf_cycles                : only with DCONV_CTRL_PERF_EN
module dconv_3x3_ctrl
  import dconv_pkg::*;
#(
  parameter int MAX_W = 256,
  parameter int MAX_H = 256,
  parameter int GAP   = GAP_DEFAULT,
  localparam int CW   = $clog2(MAX_W + 1),
  localparam int RW   = $clog2(MAX_H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cfg_w,
  input  logic [RW-1:0] cfg_h,
  output logic          krn_rd_en,
  output logic [1:0]    krn_rd_addr,
  output logic          img_rd_en,
  output logic [RW-1:0] img_rd_row,
  output logic [CW-1:0] img_rd_col,
  output logic          kernel_valid,
  output logic          image_valid,
  output logic          input_last,
  input  logic          pe_out_valid,
  output logic          res_valid,
  output logic [RW-1:0] res_row,
  output logic [CW-1:0] res_col,
  output logic          row_done,
  output logic          busy,
  output logic          done,
`ifdef DCONV_CTRL_PERF_EN
  output logic [31:0]   perf_cycles,
`endif
  output logic          err
);

  localparam int         GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [1:0] KRN_LAST = 2'(KRN_WORDS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cfg_w_q;
  logic [RW-1:0] cfg_h_q;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [1:0]    kcnt;
  logic [GW-1:0] gap_cnt;
  logic          seen_q;

  logic accept, cfg_bad, enter_stream, row_adv, col_last;
  logic krn_last_unused;

  assign cfg_bad  = (cfg_w < CW'(3)) || (cfg_h < RW'(3));
  assign col_last = (col == (cfg_w_q - CW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    enter_stream = 1'b0;
    row_adv      = 1'b0;
    row_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = cfg_bad ? S_FIN : S_LOAD_K;
        end
      end
      S_LOAD_K: begin
        if (kcnt == KRN_LAST) begin
          state_n      = S_STREAM;
          enter_stream = 1'b1;
        end
      end
      S_STREAM: begin
        if (col_last) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        // Row has drained once the PE has produced results and gone quiet.
        if (seen_q && !pe_out_valid) begin
          row_done = 1'b1;
          state_n  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          row_adv = 1'b1;
          if ((row + RW'(1)) == (cfg_h_q - RW'(2))) begin
            state_n = S_FIN;
          end else begin
            state_n      = S_STREAM;
            enter_stream = 1'b1;
          end
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_w_q <= '0;
      cfg_h_q <= '0;
      row     <= '0;
      col     <= '0;
      kcnt    <= '0;
      gap_cnt <= '0;
      seen_q  <= 1'b0;
      res_col <= '0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        cfg_w_q <= cfg_w;
        cfg_h_q <= cfg_h;
        row     <= '0;
        kcnt    <= '0;
        err     <= cfg_bad;
      end else if (state == S_LOAD_K) begin
        kcnt <= kcnt + 2'd1;
      end

      if (row_adv) row <= row + RW'(1);

      if (enter_stream)            col <= '0;
      else if (state == S_STREAM)  col <= col + CW'(1);

      if (row_done)                gap_cnt <= '0;
      else if (state == S_GAP)     gap_cnt <= gap_cnt + GW'(1);

      if (enter_stream)            seen_q <= 1'b0;
      else if (res_valid)          seen_q <= 1'b1;

      if (enter_stream)            res_col <= '0;
      else if (res_valid)          res_col <= res_col + CW'(1);
    end
  end

  assign krn_rd_en   = (state == S_LOAD_K);
  assign krn_rd_addr = krn_rd_en ? kcnt : 2'd0;
  assign img_rd_en   = (state == S_STREAM);
  assign img_rd_row  = row;
  assign img_rd_col  = col;
  assign res_valid   = pe_out_valid && ((state == S_STREAM) || (state == S_DRAIN));
  assign res_row     = row;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);

  dconv_rd_delay u_krn_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (krn_rd_en),
    .last       (kcnt == KRN_LAST),
    .valid      (kernel_valid),
    .input_last (krn_last_unused)
  );

  dconv_rd_delay u_img_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (img_rd_en),
    .last       (col_last),
    .valid      (image_valid),
    .input_last (input_last)
  );

`ifdef DCONV_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        perf_cycles <= '0;
    else if (accept)                                   perf_cycles <= '0;
    else if (busy && (perf_cycles != 32'hFFFF_FFFF))   perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
